// File: rtl/pyramid_store_if.sv
// rtl/pyramid_store_if.sv - pixel-pyramid frame store bus bundle
//
// Groups every non-clock/reset signal of pyramid_store.
//   master : pyramid generator / reader side (drives writes and read requests)
//   slave  : pyramid_store side (drives read data and status)
// Signals:
//   frame_start        start-of-frame pulse
//   pixin0..2, w_en0..2 per-level pixel and write strobe
//   rd_en, rd_level, rd_addr  read request (level 3 or out-of-range returns 0)
//   rd_data, rd_valid  registered read response, one cycle after rd_en
//   lvl_done, frame_done, ovf  per-level completion, frame pulse, sticky overflow

interface pyramid_store_if #(
  parameter int W0 = 16,
  parameter int H0 = 16
);
  localparam int AW = $clog2(W0 * H0);

  logic          frame_start;
  logic [7:0]    pixin0;
  logic [7:0]    pixin1;
  logic [7:0]    pixin2;
  logic          w_en0;
  logic          w_en1;
  logic          w_en2;
  logic          rd_en;
  logic [1:0]    rd_level;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [2:0]    lvl_done;
  logic          frame_done;
  logic [2:0]    ovf;

  modport master (
    output frame_start, pixin0, pixin1, pixin2, w_en0, w_en1, w_en2,
    output rd_en, rd_level, rd_addr,
    input  rd_data, rd_valid, lvl_done, frame_done, ovf
  );

  modport slave (
    input  frame_start, pixin0, pixin1, pixin2, w_en0, w_en1, w_en2,
    input  rd_en, rd_level, rd_addr,
    output rd_data, rd_valid, lvl_done, frame_done, ovf
  );
endinterface

// File: rtl/pyramid_store.sv
// rtl/pyramid_store.sv - three-level image pyramid frame store
//
// Stores one frame of each pyramid level (D0 = W0*H0, D1 = D0/4, D2 = D0/16
// bytes) written in raster order, and serves single-cycle registered reads.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (clears status and pointers, not arrays)
//   bus    pyramid_store_if slave modport (see interface for signal list)
// A level stops accepting writes once full; further writes set its sticky
// ovf bit. frame_start rewinds all levels without touching stored data.

module pyramid_store #(
  parameter int W0 = 16,
  parameter int H0 = 16
) (
  input logic             clk,
  input logic             reset,
  pyramid_store_if.slave  bus
);

  localparam int D0 = W0 * H0;
  localparam int D1 = D0 / 4;
  localparam int D2 = D0 / 16;
  localparam int AW = $clog2(D0);
  localparam int A1 = (D1 > 1) ? $clog2(D1) : 1;
  localparam int A2 = (D2 > 1) ? $clog2(D2) : 1;

  // Storage arrays; never reset so stale frames stay readable.
  logic [7:0] mem0 [0:D0-1];
  logic [7:0] mem1 [0:D1-1];
  logic [7:0] mem2 [0:D2-1];

  // Registered state
  logic [AW-1:0] wp0_q;
  logic [A1-1:0] wp1_q;
  logic [A2-1:0] wp2_q;
  logic [2:0]    done_q;
  logic [2:0]    ovf_q;
  logic          frame_done_q;
  logic [7:0]    rd_data_q;
  logic          rd_valid_q;

  // Next-state / write-port signals
  logic [AW-1:0] wp0_b, wp0_n;
  logic [A1-1:0] wp1_b, wp1_n;
  logic [A2-1:0] wp2_b, wp2_n;
  logic [2:0]    done_b, done_n;
  logic [2:0]    ovf_n;
  logic [2:0]    w_en;
  logic [2:0]    we;
  logic [7:0]    rd_word;

  assign w_en = {bus.w_en2, bus.w_en1, bus.w_en0};

  // frame_start acts as a rewind applied before this cycle's writes, so a
  // same-cycle write lands at address 0 and leaves the pointer at 1.
  always_comb begin
    wp0_b  = bus.frame_start ? '0 : wp0_q;
    wp1_b  = bus.frame_start ? '0 : wp1_q;
    wp2_b  = bus.frame_start ? '0 : wp2_q;
    done_b = bus.frame_start ? 3'b000 : done_q;
    ovf_n  = (bus.frame_start ? 3'b000 : ovf_q) | (w_en & done_b);
    we     = w_en & ~done_b;
    done_n = done_b;
    wp0_n  = wp0_b;
    wp1_n  = wp1_b;
    wp2_n  = wp2_b;

    // The write to the last address marks the level done; the pointer then
    // parks there instead of wrapping.
    if (we[0]) begin
      if (wp0_b == AW'(D0 - 1)) done_n[0] = 1'b1;
      else                      wp0_n     = wp0_b + 1'b1;
    end
    if (we[1]) begin
      if (wp1_b == A1'(D1 - 1)) done_n[1] = 1'b1;
      else                      wp1_n     = wp1_b + 1'b1;
    end
    if (we[2]) begin
      if (wp2_b == A2'(D2 - 1)) done_n[2] = 1'b1;
      else                      wp2_n     = wp2_b + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp0_q        <= '0;
      wp1_q        <= '0;
      wp2_q        <= '0;
      done_q       <= 3'b000;
      ovf_q        <= 3'b000;
      frame_done_q <= 1'b0;
    end else begin
      wp0_q        <= wp0_n;
      wp1_q        <= wp1_n;
      wp2_q        <= wp2_n;
      done_q       <= done_n;
      ovf_q        <= ovf_n;
      // Rising edge of "all levels complete".
      frame_done_q <= (&done_n) & ~(&done_q);
    end
  end

  // Array writes are suppressed during reset so reset has priority.
  always_ff @(posedge clk) begin
    if (!reset && we[0]) mem0[wp0_b] <= bus.pixin0;
  end

  always_ff @(posedge clk) begin
    if (!reset && we[1]) mem1[wp1_b] <= bus.pixin1;
  end

  always_ff @(posedge clk) begin
    if (!reset && we[2]) mem2[wp2_b] <= bus.pixin2;
  end

  // Read path samples the arrays before this edge's writes land, giving
  // read-first behaviour on a same-address collision.
  always_comb begin
    rd_word = 8'h00;
    case (bus.rd_level)
      2'd0: rd_word = mem0[bus.rd_addr];
      2'd1: if (bus.rd_addr < AW'(D1)) rd_word = mem1[bus.rd_addr[A1-1:0]];
      2'd2: if (bus.rd_addr < AW'(D2)) rd_word = mem2[bus.rd_addr[A2-1:0]];
      default: rd_word = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= rd_word;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.lvl_done   = done_q;
  assign bus.frame_done = frame_done_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_pyramid_store.sv
// tb/tb_pyramid_store.sv - scoreboard testbench for pyramid_store (W0=H0=8)

module tb_pyramid_store;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [7:0] exp_q [$];

  pyramid_store_if #(.W0(8), .H0(8)) bus ();

  pyramid_store #(.W0(8), .H0(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] lvl, input logic [5:0] addr, input logic [7:0] e);
    bus.rd_en    = 1'b1;
    bus.rd_level = lvl;
    bus.rd_addr  = addr;
    exp_q.push_back(e);
    step();
    bus.rd_en    = 1'b0;
  endtask

  // Monitor: every valid read response must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected actual=%0h expected=no_response", bus.rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.rd_data !== e) begin
          failures++;
          $display("FAIL rd_data actual=%0h expected=%0h", bus.rd_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    bus.frame_start = 1'b0;
    bus.pixin0 = 8'h00; bus.pixin1 = 8'h00; bus.pixin2 = 8'h00;
    bus.w_en1 = 1'b0; bus.w_en2 = 1'b0;
    bus.rd_en = 1'b0; bus.rd_level = 2'd0; bus.rd_addr = '0;

    // Reset held two cycles with a write strobe active.
    reset = 1'b1;
    bus.w_en0  = 1'b1;
    bus.pixin0 = 8'hEE;
    step();
    step();
    chk("rst_rd_data", bus.rd_data, 8'h00);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_lvl_done", bus.lvl_done, 3'b000);
    chk("rst_frame_done", bus.frame_done, 1'b0);
    chk("rst_ovf", bus.ovf, 3'b000);

    // Fill level 0 with 0..63.
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.pixin0 = i[7:0];
      bus.w_en0  = 1'b1;
      step();
      if (i == 62) chk("l0_not_done_63", bus.lvl_done, 3'b000);
    end
    bus.w_en0 = 1'b0;
    chk("l0_done", bus.lvl_done, 3'b001);
    rd(2'd0, 6'd10, 8'd10);
    rd(2'd0, 6'd0, 8'd0);
    rd(2'd0, 6'd63, 8'd63);
    step();

    // Levels 1 and 2 interleaved; level 1 finishes last.
    for (int i = 0; i < 16; i++) begin
      bus.pixin1 = 8'h10 + i[7:0];
      bus.w_en1  = 1'b1;
      bus.pixin2 = 8'h20 + i[7:0];
      bus.w_en2  = (i < 4);
      if (i == 15) chk("frame_done_early", bus.frame_done, 1'b0);
      step();
    end
    bus.w_en1 = 1'b0;
    bus.w_en2 = 1'b0;
    chk("frame_done_pulse", bus.frame_done, 1'b1);
    chk("all_done", bus.lvl_done, 3'b111);
    step();
    chk("frame_done_once", bus.frame_done, 1'b0);

    // Overflow on level 1.
    bus.pixin1 = 8'hFF;
    bus.w_en1  = 1'b1;
    step();
    bus.w_en1  = 1'b0;
    chk("ovf_l1", bus.ovf, 3'b010);
    rd(2'd1, 6'd0, 8'h10);
    rd(2'd1, 6'd15, 8'h1F);
    rd(2'd1, 6'd16, 8'h00);
    chk("ovf_sticky", bus.ovf, 3'b010);

    // frame_start with a same-cycle level-2 write.
    bus.frame_start = 1'b1;
    bus.pixin2 = 8'hAA;
    bus.w_en2  = 1'b1;
    step();
    bus.frame_start = 1'b0;
    chk("fs_lvl_done", bus.lvl_done, 3'b000);
    chk("fs_ovf", bus.ovf, 3'b000);
    bus.pixin2 = 8'hBB;
    step();
    bus.w_en2 = 1'b0;
    rd(2'd2, 6'd0, 8'hAA);
    rd(2'd2, 6'd1, 8'hBB);
    rd(2'd2, 6'd2, 8'h22);
    rd(2'd2, 6'd4, 8'h00);
    rd(2'd0, 6'd10, 8'd10);
    step();

    // Read-first collision at level 0 address 5.
    for (int i = 0; i < 5; i++) begin
      bus.pixin0 = i[7:0];
      bus.w_en0  = 1'b1;
      step();
    end
    bus.pixin0 = 8'h55;
    rd(2'd0, 6'd5, 8'h05);
    bus.w_en0 = 1'b0;
    rd(2'd0, 6'd5, 8'h55);
    rd(2'd3, 6'd5, 8'h00);
    step();

    // Reset mid-frame: next write goes to address 0.
    bus.pixin0 = 8'hC0; bus.w_en0 = 1'b1; step();
    bus.pixin0 = 8'hC1; step();
    bus.w_en0 = 1'b0;
    reset = 1'b1;
    step();
    chk("midrst_rd_data", bus.rd_data, 8'h00);
    chk("midrst_valid", bus.rd_valid, 1'b0);
    reset = 1'b0;
    bus.pixin0 = 8'h77; bus.w_en0 = 1'b1;
    step();
    bus.w_en0 = 1'b0;
    rd(2'd0, 6'd0, 8'h77);
    rd(2'd0, 6'd6, 8'hC0);
    rd(2'd0, 6'd1, 8'h01);

    step(); step(); step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pyramid_store.md
PYRAMID_STORE -- requirements
Module: pyramid_store

Interface
REQ-001 SHALL have parameter W0, default 16, meaning level-0 image width in pixels (power of 2, >= 4).
REQ-002 SHALL have parameter H0, default 16, meaning level-0 image height in pixels (power of 2, >= 4).
REQ-003 SHALL derive depths D0 = W0*H0, D1 = D0/4, D2 = D0/16, and AW = log2(D0).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port frame_start, input, 1, one-cycle pulse that starts a new frame.
REQ-007 SHALL have ports pixin0, pixin1, pixin2, input, 8 each, level 0/1/2 pixels from the pyramid generator.
REQ-008 SHALL have ports w_en0, w_en1, w_en2, input, 1 each, per-level write strobes qualifying pixinN.
REQ-009 SHALL have port rd_en, input, 1, read request.
REQ-010 SHALL have port rd_level, input, 2, level selected for read.
REQ-011 SHALL have port rd_addr, input, AW, raster address within the selected level.
REQ-012 SHALL have port rd_data, output, 8, registered read data.
REQ-013 SHALL have port rd_valid, output, 1, qualifies rd_data.
REQ-014 SHALL have port lvl_done, output, 3, bit N set when level N holds a complete image.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse when all three levels are complete.
REQ-016 SHALL have port ovf, output, 3, bit N sticky when a level-N write arrived while level N was full.

Function
REQ-017 SHALL keep three independent storage arrays of depth D0, D1, D2 (8-bit words) and write pointers wp0..wp2.
REQ-018 SHALL, on w_enN with lvl_done[N]=0, write pixinN to array N at wpN and increment wpN on the same edge.
REQ-019 SHALL set lvl_done[N] on the edge that writes address DN-1; wpN then holds and no wrap occurs.
REQ-020 SHALL, on w_enN with lvl_done[N]=1, discard the write, leave array N unchanged, and set ovf[N].
REQ-021 SHALL pulse frame_done high for exactly the one cycle following the edge where &lvl_done first becomes 1.
REQ-022 SHALL, on frame_start, clear lvl_done, ovf and all wpN; a same-cycle w_enN writes address 0 and leaves wpN = 1.
REQ-023 SHALL not alter the array contents on frame_start; stale data remains readable.
REQ-024 SHALL, on rd_en, present the addressed word on rd_data and set rd_valid on the next edge (latency 1 cycle).
REQ-025 SHALL drive rd_valid low in any cycle following a cycle with rd_en=0; rd_data holds its last value.
REQ-026 SHALL return rd_data = 0 with rd_valid = 1 when rd_level = 3 or rd_addr >= D(rd_level).
REQ-027 SHALL give read-first behaviour: a read and write to the same level and address in one cycle return the old word.
REQ-028 SHALL process writes to the three levels and a read in the same cycle without stalls or ordering dependency.

Reset
REQ-029 SHALL, while reset=1, drive rd_data=0, rd_valid=0, lvl_done=0, frame_done=0, ovf=0 and clear wp0..wp2.
REQ-030 SHALL give reset priority over frame_start, w_enN and rd_en; array contents are not cleared.
REQ-031 SHALL, on reset mid-frame, discard the partial frame's progress; the next write to each level goes to address 0.

Verification (W0=H0=8: D0=64, D1=16, D2=4)
REQ-032 Reset asserted 2 cycles with w_en0=1 -> all outputs 0; wp0 stays 0; first write after release lands at address 0.
REQ-033 64 w_en0 writes of values 0..63, then rd_en level 0 addr 10 -> rd_data=10, rd_valid=1 one cycle later; lvl_done=3'b001 after the 64th write.
REQ-034 Complete levels 0, 1, 2 in interleaved order -> frame_done high exactly one cycle after the last level's final write; lvl_done=3'b111.
REQ-035 17th w_en1 with pixin1=8'hFF after level 1 full -> ovf=3'b010; level-1 address 0 and 15 unchanged on readback.
REQ-036 frame_start with w_en2=1, pixin2=8'hAA -> lvl_done=0, ovf=0; level-2 address 0 reads 8'hAA; next w_en2 lands at address 1.
REQ-037 Same-cycle write 8'h55 and read of level 0 address 5 (old 8'h05) -> rd_data=8'h05; next read -> 8'h55; rd_level=3 -> rd_data=0, rd_valid=1.
